ch_aggregator: RTL and testbench

- Stage directly downstream of the cluster-head role check; consumes its forAggregation flag and done pulse (wired to start).
- On a cluster-head node, reads the member-packet count and buffered member readings from node memory, computes a saturated sum and the maximum, and writes both back.
- Then read-modify-writes the internal flags word: clears the aggregation-pending bit and sets the aggregation-complete bit.
- Non-cluster-head nodes get an immediate done with no memory traffic.

---
 rtl/ch_aggregator.sv | 167 ++++++++++++++++
 tb/tb_ch_aggregator.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ch_aggregator.sv
// ch_aggregator: on a cluster-head node, sums (saturated) and maxes the buffered member
// readings, writes both results back to memory, then marks aggregation complete in the flags word.
`default_nettype none

module ch_aggregator #(
  parameter int                  WORD_WIDTH = 16,
  parameter int                  ADDR_WIDTH = 11,
  parameter logic [ADDR_WIDTH-1:0] FLAGS_ADDR = 11'h001,
  parameter logic [ADDR_WIDTH-1:0] COUNT_ADDR = 11'h002,
  parameter logic [ADDR_WIDTH-1:0] SUM_ADDR   = 11'h003,
  parameter logic [ADDR_WIDTH-1:0] MAX_ADDR   = 11'h004,
  parameter logic [ADDR_WIDTH-1:0] PKT_BASE   = 11'h100,
  parameter int                  MAX_PKTS   = 16
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  forAggregation,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CNT_WAIT = 4'd1,
    S_CNT_CAP  = 4'd2,
    S_PKT_WAIT = 4'd3,
    S_PKT_CAP  = 4'd4,
    S_WR_SUM   = 4'd5,
    S_WR_MAX   = 4'd6,
    S_FLG_WAIT = 4'd7,
    S_FLG_CAP  = 4'd8,
    S_WR_FLG   = 4'd9,
    S_DONE     = 4'd10
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [WORD_WIDTH-1:0]   r_dout;
  logic                    r_wr_en;
  logic                    r_done;
  logic [WORD_WIDTH+3:0]   r_acc;
  logic [WORD_WIDTH-1:0]   r_max;
  logic [4:0]              r_idx;
  logic [4:0]              r_cnt;

  logic [4:0]              w_cnt;
  logic [4:0]              w_idx_nxt;
  logic [WORD_WIDTH+3:0]   w_acc_nxt;
  logic [WORD_WIDTH-1:0]   w_max_nxt;
  logic [WORD_WIDTH-1:0]   w_sum_sat;
  logic [WORD_WIDTH-1:0]   w_flags;

  always_comb begin
    w_cnt     = (data_in[4:0] > 5'(MAX_PKTS)) ? 5'(MAX_PKTS) : data_in[4:0];
    w_idx_nxt = r_idx + 5'd1;
    w_acc_nxt = r_acc + {4'd0, data_in};
    w_max_nxt = (data_in > r_max) ? data_in : r_max;
    // Any bit above the word width means the sum no longer fits.
    w_sum_sat = (|w_acc_nxt[WORD_WIDTH+3:WORD_WIDTH]) ? {WORD_WIDTH{1'b1}}
                                                      : w_acc_nxt[WORD_WIDTH-1:0];
    w_flags    = data_in;
    w_flags[6] = 1'b0;
    w_flags[5] = 1'b1;
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_dout  <= '0;
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      r_acc   <= '0;
      r_max   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      if (!en && r_state != S_IDLE) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && en) begin
              if (forAggregation) begin
                r_addr  <= COUNT_ADDR;
                r_state <= S_CNT_WAIT;
              end else begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end
          end
          S_CNT_WAIT: r_state <= S_CNT_CAP;
          S_CNT_CAP: begin
            r_cnt <= w_cnt;
            r_idx <= '0;
            r_acc <= '0;
            r_max <= '0;
            if (w_cnt == 5'd0) begin
              r_addr  <= SUM_ADDR;
              r_dout  <= '0;
              r_wr_en <= 1'b1;
              r_state <= S_WR_SUM;
            end else begin
              r_addr  <= PKT_BASE;
              r_state <= S_PKT_WAIT;
            end
          end
          S_PKT_WAIT: r_state <= S_PKT_CAP;
          S_PKT_CAP: begin
            r_acc <= w_acc_nxt;
            r_max <= w_max_nxt;
            if (w_idx_nxt == r_cnt) begin
              r_addr  <= SUM_ADDR;
              r_dout  <= w_sum_sat;
              r_wr_en <= 1'b1;
              r_state <= S_WR_SUM;
            end else begin
              r_idx   <= w_idx_nxt;
              r_addr  <= PKT_BASE + ADDR_WIDTH'(w_idx_nxt);
              r_state <= S_PKT_WAIT;
            end
          end
          S_WR_SUM: begin
            r_addr  <= MAX_ADDR;
            r_dout  <= r_max;
            r_wr_en <= 1'b1;
            r_state <= S_WR_MAX;
          end
          S_WR_MAX: begin
            r_addr  <= FLAGS_ADDR;
            r_state <= S_FLG_WAIT;
          end
          S_FLG_WAIT: r_state <= S_FLG_CAP;
          S_FLG_CAP: begin
            r_dout  <= w_flags;
            r_wr_en <= 1'b1;
            r_state <= S_WR_FLG;
          end
          S_WR_FLG: begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign address  = r_addr;
  assign data_out = r_dout;
  assign wr_en    = r_wr_en;
  assign done     = r_done;
  assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_ch_aggregator.sv
// Directed bench for ch_aggregator with a synchronous-read memory model and write logging.
`default_nettype none

module tb_ch_aggregator;

  logic        clock = 1'b0;
  logic        nrst = 1'b0;
  logic        en = 1'b0;
  logic        start = 1'b0;
  logic        forAggregation = 1'b0;
  logic [15:0] data_in = '0;
  logic [10:0] address;
  logic        wr_en;
  logic [15:0] data_out;
  logic        busy;
  logic        done;

  ch_aggregator dut (
    .clock(clock), .nrst(nrst), .en(en), .start(start),
    .forAggregation(forAggregation), .data_in(data_in),
    .address(address), .wr_en(wr_en), .data_out(data_out),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [0:2047];
  logic        tb_we = 1'b0;
  logic [10:0] tb_a = '0;
  logic [15:0] tb_d = '0;
  logic [10:0] wlog_a [0:255];
  logic [15:0] wlog_d [0:255];
  int          wr_count = 0;
  int          done_count = 0;
  int          pkt_reads = 0;
  logic [10:0] prev_addr = '0;
  logic [10:0] max_pkt_addr = '0;

  always @(posedge clock) begin
    data_in <= mem[address];
    if (wr_en) begin
      mem[address] <= data_out;
      wlog_a[wr_count[7:0]] <= address;
      wlog_d[wr_count[7:0]] <= data_out;
      wr_count <= wr_count + 1;
    end
    if (tb_we) mem[tb_a] <= tb_d;
    if (done) done_count <= done_count + 1;
    if (address != prev_addr && address >= 11'h100 && address <= 11'h1FF) begin
      pkt_reads <= pkt_reads + 1;
      if (address > max_pkt_addr) max_pkt_addr <= address;
    end
    prev_addr <= address;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [10:0] a, input logic [15:0] d);
    @(negedge clock);
    tb_we = 1'b1; tb_a = a; tb_d = d;
    @(negedge clock);
    tb_we = 1'b0;
  endtask

  // Pulses start for one edge, optionally re-pulses it at cycle inj, returns the done cycle.
  task automatic run(input logic fa, input int inj, output int cyc);
    @(negedge clock);
    forAggregation = fa;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    cyc = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      if (done) begin
        cyc = c;
        break;
      end
      start = (c == inj);
    end
    start = 1'b0;
  endtask

  int cyc;
  int wb;
  int db;
  int pb;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    #12;
    chk("reset_outputs", {address, data_out, wr_en, done, busy}, '0);
    @(negedge clock);
    nrst = 1'b1;
    en = 1'b1;

    // 1: non-cluster-head
    wb = wr_count;
    run(1'b0, 0, cyc);
    chk("nonch_done_cycle", cyc, 1);
    chk("nonch_busy", busy, 0);
    repeat (3) @(negedge clock);
    chk("nonch_writes", wr_count - wb, 0);
    chk("nonch_address", address, 11'h000);

    // 2: normal aggregation
    poke(11'h002, 16'h0003);
    poke(11'h100, 16'h0010);
    poke(11'h101, 16'h0200);
    poke(11'h102, 16'h0005);
    poke(11'h001, 16'h00C0);
    wb = wr_count;
    run(1'b1, 0, cyc);
    chk("norm_done_cycle", cyc, 14);
    @(negedge clock);
    chk("norm_nwrites", wr_count - wb, 3);
    chk("norm_w0_addr", wlog_a[wb], 11'h003);
    chk("norm_w0_data", wlog_d[wb], 16'h0215);
    chk("norm_w1_addr", wlog_a[wb+1], 11'h004);
    chk("norm_w1_data", wlog_d[wb+1], 16'h0200);
    chk("norm_w2_addr", wlog_a[wb+2], 11'h001);
    chk("norm_w2_data", wlog_d[wb+2], 16'h00A0);
    chk("norm_idle", {busy, done}, 2'b00);

    // 3: saturation and count clamp
    poke(11'h002, 16'h001F);
    for (int i = 0; i < 16; i++) poke(11'h100 + 11'(i), 16'hFFFF);
    poke(11'h110, 16'h1234);
    wb = wr_count;
    pb = pkt_reads;
    run(1'b1, 0, cyc);
    chk("clamp_done_cycle", cyc, 40);
    @(negedge clock);
    chk("clamp_pkt_reads", pkt_reads - pb, 16);
    chk("clamp_max_addr", max_pkt_addr, 11'h10F);
    chk("clamp_sum", mem[3], 16'hFFFF);
    chk("clamp_max", mem[4], 16'hFFFF);
    chk("clamp_flags", mem[1], 16'h00A0);
    chk("clamp_nwrites", wr_count - wb, 3);

    // 4: empty cluster, upper count bits ignored
    poke(11'h002, 16'h00E0);
    poke(11'h001, 16'h0040);
    wb = wr_count;
    run(1'b1, 0, cyc);
    chk("empty_done_cycle", cyc, 8);
    @(negedge clock);
    chk("empty_sum", mem[3], 16'h0000);
    chk("empty_max", mem[4], 16'h0000);
    chk("empty_flags", mem[1], 16'h0020);
    chk("empty_nwrites", wr_count - wb, 3);

    // 5a: abort via en during PKT_WAIT
    poke(11'h002, 16'h0003);
    wb = wr_count;
    db = done_count;
    @(negedge clock);
    forAggregation = 1'b1;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (3) @(negedge clock);
    chk("abort_busy_before", busy, 1);
    en = 1'b0;
    @(negedge clock);
    chk("abort_busy_after", busy, 0);
    repeat (25) @(negedge clock);
    chk("abort_no_writes", wr_count - wb, 0);
    chk("abort_no_done", done_count - db, 0);
    en = 1'b1;

    // 5b: asynchronous reset mid-operation
    @(negedge clock);
    forAggregation = 1'b1;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (5) @(negedge clock);
    chk("rst_addr_before", address, 11'h101);
    nrst = 1'b0;
    #1;
    chk("rst_async_outputs", {address, data_out, wr_en, done, busy}, '0);
    @(negedge clock);
    nrst = 1'b1;
    repeat (25) @(negedge clock);
    chk("rst_no_writes", wr_count - wb, 0);
    chk("rst_no_done", done_count - db, 0);

    // 6: back-to-back, stray start while busy ignored
    poke(11'h002, 16'h0002);
    poke(11'h100, 16'h0003);
    poke(11'h101, 16'h0007);
    poke(11'h001, 16'h0041);
    wb = wr_count;
    db = done_count;
    run(1'b1, 3, cyc);
    chk("b2b1_done_cycle", cyc, 12);
    repeat (20) @(negedge clock);
    chk("b2b1_single_done", done_count - db, 1);
    chk("b2b1_nwrites", wr_count - wb, 3);
    chk("b2b1_sum", mem[3], 16'h000A);
    chk("b2b1_max", mem[4], 16'h0007);
    chk("b2b1_flags", mem[1], 16'h0021);
    poke(11'h100, 16'h8000);
    poke(11'h101, 16'h9000);
    wb = wr_count;
    run(1'b1, 0, cyc);
    chk("b2b2_done_cycle", cyc, 12);
    @(negedge clock);
    chk("b2b2_sum", mem[3], 16'hFFFF);
    chk("b2b2_max", mem[4], 16'h9000);
    chk("b2b2_flags", mem[1], 16'h0021);
    chk("b2b2_nwrites", wr_count - wb, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
